instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at pc, holds it until the datapath
// commits, then advances pc (jump, taken branch, or sequential).
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        commit,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic [1:0]  state_o
);

    // Handshake: imem_req is high for every FETCH cycle with imem_addr held at pc;
    // a word is taken only in a FETCH cycle with imem_ack=1. instr_valid is high
    // for every HOLD cycle; the held word retires in the HOLD cycle with commit=1.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  wait_q, wait_d;
    logic        err_q, err_d;

    logic [31:0] pcp4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    // Jump is active-low and outranks a taken branch.
    always_comb begin
        pcp4       = pc_q + 32'd4;
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        next_pc    = pcp4;
        if (!Jump) begin
            next_pc = {pcp4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pcp4 + branch_off;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        wait_d      = wait_q;
        err_d       = err_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack in the final allowed cycle still counts as a fetch.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    wait_d  = 4'd0;
                    state_d = S_HOLD;
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (commit) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            wait_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign OP        = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign fetch_err = err_q;
    assign state_o   = state_q;

endmodule
